// File: rtl/ps2_pkg.sv
// Shared scancode constants and prefix-FSM state type for the PS/2 key decoder.
package ps2_pkg;

  // Scancode-set-2 prefixes and the default bound keys
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit 0 = E0 seen, bit 1 = F0 seen
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXT     = 2'b01,
    ST_BRK     = 2'b10,
    ST_EXT_BRK = 2'b11
  } prefix_state_e;

  // True for the two prefix bytes that only move the FSM
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BREAK);
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Prefix tracker for the PS/2 byte stream. Folds E0/F0 prefixes into a state,
// discards a stale prefix after TIMEOUT_CYCLES idle clocks, and presents each
// final code byte as a make or break strobe with its ext flag.
//
// Strobe semantics: make_o/brk_o are single-cycle and valid in the same cycle
// as the rx_valid_i that carried the final code byte; code_o and ext_o are
// only meaningful while one of the strobes is high. There is no back-pressure.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          soft_clear_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          make_o,
  output logic          brk_o,
  output logic          ext_o,
  output logic [7:0]    code_o,
  output prefix_state_e state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  prefix_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // Decode the strobes from the current prefix state; soft clear drops the byte
  always_comb begin
    accept = rx_valid_i && !soft_clear_i && !is_prefix(rx_data_i);
    make_o = accept && (state_q == ST_IDLE || state_q == ST_EXT);
    brk_o  = accept && (state_q == ST_BRK  || state_q == ST_EXT_BRK);
    ext_o  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    code_o = rx_data_i;
  end

  // Prefix state and idle timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (soft_clear_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (rx_valid_i) begin
      cnt_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data_i == SC_EXT)        state_q <= ST_EXT;
          else if (rx_data_i == SC_BREAK) state_q <= ST_BRK;
          else                            state_q <= ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data_i == SC_BREAK)      state_q <= ST_EXT_BRK;
          else if (rx_data_i == SC_EXT)   state_q <= ST_EXT;
          else                            state_q <= ST_IDLE;
        end
        ST_BRK: begin
          if (rx_data_i == SC_EXT)        state_q <= ST_EXT_BRK;
          else if (rx_data_i == SC_BREAK) state_q <= ST_BRK;
          else                            state_q <= ST_IDLE;
        end
        default: begin
          if (is_prefix(rx_data_i))       state_q <= ST_EXT_BRK;
          else                            state_q <= ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A prefix whose follow-up byte was lost must not taint the next key
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode-set-2 key decoder: maps NUM_KEYS programmable codes (optionally
// E0-extended) to press/release pulses and held levels for the game logic.
// Optional build macro PS2_TYPEMATIC_REPEAT_EN: when defined, a make of an
// already-held key re-pulses key_press and updates last_key (auto-repeat).
// KEY_CODES holds key 0 in the lowest byte.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {SC_LEFT, SC_SPACE, SC_ENTER, SC_BKSP},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1000,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                soft_clear,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [3:0]          last_key,
  output logic                any_held
);

  logic          make_s;
  logic          brk_s;
  logic          ext_s;
  logic [7:0]    code_s;
  prefix_state_e fsm_state;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .soft_clear_i(soft_clear),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .make_o      (make_s),
    .brk_o       (brk_s),
    .ext_o       (ext_s),
    .code_o      (code_s),
    .state_o     (fsm_state)
  );

  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] held_q,    held_d;
  logic [3:0]          last_q,    last_d;
  logic [NUM_KEYS-1:0] match;

  // Key table lookup; ascending loop lets the highest matching index own last_key
  always_comb begin
    press_d   = '0;
    release_d = '0;
    held_d    = held_q;
    last_d    = last_q;
    match     = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (code_s == KEY_CODES[8*i +: 8]) && (ext_s == KEY_EXT[i]);
      if (make_s && match[i]) begin
`ifdef PS2_TYPEMATIC_REPEAT_EN
        press_d[i] = 1'b1;
        held_d[i]  = 1'b1;
        last_d     = 4'(i);
`else
        if (!held_q[i]) begin
          press_d[i] = 1'b1;
          held_d[i]  = 1'b1;
          last_d     = 4'(i);
        end
`endif
      end
      if (brk_s && match[i] && held_q[i]) begin
        release_d[i] = 1'b1;
        held_d[i]    = 1'b0;
      end
    end
    // Game reset clears held keys silently, without release pulses
    if (soft_clear) begin
      press_d   = '0;
      release_d = '0;
      held_d    = '0;
      last_d    = '0;
    end
  end

  // Registered key outputs, one cycle after the accepted byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      press_q   <= '0;
      release_q <= '0;
      held_q    <= '0;
      last_q    <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
      last_q    <= last_d;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign last_key    = last_q;
  assign any_held    = |held_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder with a shortened prefix timeout.
module tb_ps2_key_decoder;

  localparam int NK  = 4;
  localparam int TMO = 64;
  localparam int EW  = 3*NK + 4 + 1;

  logic          clk;
  logic          resetn;
  logic          soft_clear;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_held;
  logic [3:0]    last_key;
  logic          any_held;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected output events: {press, release, held, last_key, any_held}
  logic [EW-1:0] exp_q[$];

  ps2_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ({8'h6B, 8'h29, 8'h5A, 8'h66}),
    .KEY_EXT       (4'b1000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_clear (soft_clear),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .key_press  (key_press),
    .key_release(key_release),
    .key_held   (key_held),
    .last_key   (last_key),
    .any_held   (any_held)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [NK-1:0] p, input logic [NK-1:0] r,
                          input logic [NK-1:0] h, input logic [3:0] l);
    exp_q.push_back({p, r, h, l, |h});
  endtask

  // Driver: one byte, one strobe cycle, one idle cycle
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the next expected event
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      if (resetn && ((key_press | key_release) != '0)) begin
        act = {key_press, key_release, key_held, last_key, any_held};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          chk("event", 32'(act), 32'(exp));
        end
      end
    end
  end

  initial begin
    resetn     = 1'b0;
    soft_clear = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    idle(3);
    chk("reset_held",    32'(key_held),    32'h0);
    chk("reset_press",   32'(key_press),   32'h0);
    chk("reset_release", 32'(key_release), 32'h0);
    chk("reset_last",    32'(last_key),    32'h0);
    chk("reset_any",     32'(any_held),    32'h0);
    resetn = 1'b1;
    idle(2);

    // Plain make/break of key 2
    push_exp(4'b0100, 4'b0000, 4'b0100, 4'd2); send(8'h29);
    send(8'hF0); push_exp(4'b0000, 4'b0100, 4'b0000, 4'd2); send(8'h29);

    // Extended key 3; the non-extended code must not touch it
    send(8'hE0); push_exp(4'b1000, 4'b0000, 4'b1000, 4'd3); send(8'h6B);
    send(8'h6B);
    send(8'hE0); send(8'hF0); push_exp(4'b0000, 4'b1000, 4'b0000, 4'd3); send(8'h6B);

    // Typematic repeats of key 1
    push_exp(4'b0010, 4'b0000, 4'b0010, 4'd1); send(8'h5A);
`ifdef PS2_TYPEMATIC_REPEAT_EN
    push_exp(4'b0010, 4'b0000, 4'b0010, 4'd1); send(8'h5A);
    push_exp(4'b0010, 4'b0000, 4'b0010, 4'd1); send(8'h5A);
`else
    send(8'h5A);
    send(8'h5A);
`endif
    send(8'hF0); push_exp(4'b0000, 4'b0010, 4'b0000, 4'd1); send(8'h5A);

    // Pause byte is an ordinary non-matching code
    send(8'hE1);

    // Repeated prefixes: E0 E0 make, F0 E0 break
    send(8'hE0); send(8'hE0); push_exp(4'b1000, 4'b0000, 4'b1000, 4'd3); send(8'h6B);
    send(8'hF0); send(8'hE0); push_exp(4'b0000, 4'b1000, 4'b0000, 4'd3); send(8'h6B);

    // Short gap keeps the F0 pending: break of a non-held key, no effect
    send(8'hF0); idle(10); send(8'h66);
    // Long gap discards the F0: the byte is a make
    send(8'hF0); idle(TMO + 5); push_exp(4'b0001, 4'b0000, 4'b0001, 4'd0); send(8'h66);
    send(8'hF0); push_exp(4'b0000, 4'b0001, 4'b0000, 4'd0); send(8'h66);

    // Soft clear wins over a concurrent F0
    push_exp(4'b0001, 4'b0000, 4'b0001, 4'd0); send(8'h66);
    push_exp(4'b0100, 4'b0000, 4'b0101, 4'd2); send(8'h29);
    @(negedge clk);
    rx_data    = 8'hF0;
    rx_valid   = 1'b1;
    soft_clear = 1'b1;
    @(negedge clk);
    rx_valid   = 1'b0;
    soft_clear = 1'b0;
    chk("clear_held", 32'(key_held), 32'h0);
    chk("clear_last", 32'(last_key), 32'h0);
    chk("clear_any",  32'(any_held), 32'h0);
    push_exp(4'b0100, 4'b0000, 4'b0100, 4'd2); send(8'h29);
    send(8'hF0); push_exp(4'b0000, 4'b0100, 4'b0000, 4'd2); send(8'h29);

    // Asynchronous reset mid-sequence after E0
    push_exp(4'b0001, 4'b0000, 4'b0001, 4'd0); send(8'h66);
    send(8'hE0);
    #2 resetn = 1'b0;
    #1;
    chk("areset_held", 32'(key_held), 32'h0);
    chk("areset_last", 32'(last_key), 32'h0);
    chk("areset_any",  32'(any_held), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
    send(8'h6B);
    push_exp(4'b0001, 4'b0000, 4'b0001, 4'd0); send(8'h66);
    send(8'hF0); push_exp(4'b0000, 4'b0001, 4'b0000, 4'd0); send(8'h66);

    idle(5);
    chk("leftover_expected", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
